// File: rtl/seq_mul_n.sv
// seq_mul_n: parametrised shift-add sequential multiplier, W-bit a x b -> 2W-bit op,
// one multiplier bit per clock, optional two's complement mode, busy/done handshake.
module seq_mul_n #(
  parameter int W         = 4,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] op
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [2*W-1:0] mcand;   // multiplicand, pre-shifted to the weight of the current multiplier bit
  logic [2*W-1:0] acc;
  logic [W-1:0]   mult;
  logic [CW-1:0]  cnt;
  logic           neg;

  logic           mode_s;
  logic [W-1:0]   mag_a;
  logic [W-1:0]   mag_b;
  logic [2*W-1:0] addend;
  logic [2*W-1:0] sum;

  // Operand magnitudes at start, and the partial-product sum for the current RUN step
  always_comb begin
    mode_s = signed_mode & SIGNED_EN;
    mag_a  = (mode_s && a[W-1]) ? -a : a;
    mag_b  = (mode_s && b[W-1]) ? -b : b;
    addend = mult[0] ? mcand : '0;
    sum    = acc + addend;
  end

  // Control FSM and datapath; the shifting mcand register replaces mcand<<(W-cnt)
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mcand <= '0;
      acc   <= '0;
      mult  <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      op    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= {{W{1'b0}}, mag_a};
            mult  <= mag_b;
            neg   <= mode_s & (a[W-1] ^ b[W-1]);
            acc   <= '0;
            cnt   <= CW'(W);
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc   <= sum;
          mcand <= mcand << 1;
          mult  <= mult >> 1;
          cnt   <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            op    <= neg ? -sum : sum;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
